retire_stage: RTL and testbench

RETIRE_STAGE -- requirements
Module: retire_stage

---
 rtl/retire_stage.sv | 175 +++++++++++++++++
 tb/tb_retire_stage.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/retire_stage.sv
// Retire stage: commits up to three ROB entries per cycle (slot 2 oldest),
// updates the architectural map and free list, counts retired stores and
// instructions, and raises a one-cycle recovery pulse or a sticky halt.
//
// Ports:
//   clock, reset        - clock; synchronous active-low reset
//   retire_entry        - three packed ROB entries, slot 2 in the top bits;
//                         per-entry layout (msb..lsb): valid, PC, arch_reg,
//                         Tnew, Told, halt, is_store, precise_state_need,
//                         target_pc
//   map_wr_en/ar/pr     - per-slot architectural map writes
//   free_en/free_pr     - per-slot free-list returns (Told)
//   sq_retire_num       - stores committed this cycle
//   BPRecoverEN         - one-cycle flush pulse
//   recover_pc          - redirect target while BPRecoverEN is high
//   halt                - sticky halted flag
//   retired_count       - instructions committed since reset

`ifndef XLEN
`define XLEN 32
`endif
`ifndef PR
`define PR 6
`endif

module retire_stage (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [3*(2*`XLEN+2*`PR+9)-1:0] retire_entry,
    output logic [2:0]                 map_wr_en,
    output logic [2:0][4:0]            map_wr_ar,
    output logic [2:0][`PR-1:0]        map_wr_pr,
    output logic [2:0]                 free_en,
    output logic [2:0][`PR-1:0]        free_pr,
    output logic [1:0]                 sq_retire_num,
    output logic                       BPRecoverEN,
    output logic [`XLEN-1:0]           recover_pc,
    output logic                       halt,
    output logic [63:0]                retired_count
);

    localparam int EW = 2*`XLEN + 2*`PR + 9;

    localparam logic [1:0] NORMAL  = 2'd0;
    localparam logic [1:0] RECOVER = 2'd1;
    localparam logic [1:0] HALTED  = 2'd2;

    logic [1:0] state;
    logic [1:0] state_nxt;

    // Unpacked entry fields
    logic [2:0]             v_f;
    logic [2:0]             halt_f;
    logic [2:0]             store_f;
    logic [2:0]             psn_f;
    logic [2:0][4:0]        ar_f;
    logic [2:0][`PR-1:0]    tnew_f;
    logic [2:0][`PR-1:0]    told_f;
    logic [2:0][`XLEN-1:0]  tpc_f;
    logic [2:0][`XLEN-1:0]  pc_f;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            tpc_f[i]   = retire_entry[i*EW +: `XLEN];
            psn_f[i]   = retire_entry[i*EW + `XLEN];
            store_f[i] = retire_entry[i*EW + `XLEN + 1];
            halt_f[i]  = retire_entry[i*EW + `XLEN + 2];
            told_f[i]  = retire_entry[i*EW + `XLEN + 3 +: `PR];
            tnew_f[i]  = retire_entry[i*EW + `XLEN + 3 + `PR +: `PR];
            ar_f[i]    = retire_entry[i*EW + `XLEN + 3 + 2*`PR +: 5];
            pc_f[i]    = retire_entry[i*EW + `XLEN + 8 + 2*`PR +: `XLEN];
            v_f[i]     = retire_entry[i*EW + EW - 1];
        end
    end

    // PC travels with the entry but nothing at commit needs it.
    logic unused_pc;
    assign unused_pc = ^pc_f;

    logic [2:0]            elig;
    logic [2:0]            stop;
    logic [2:0]            commit;
    logic [2:0]            rec_vec;
    logic                  halt_hit;
    logic                  recover_hit;
    logic [`XLEN-1:0]      rec_target;
    logic [2:0]            wr_en;
    logic [2:0][4:0]       wr_ar;
    logic [2:0][`PR-1:0]   wr_pr;
    logic [2:0][`PR-1:0]   fr_pr;
    logic [1:0]            n_commit;
    logic [1:0]            n_store;

    always_comb begin
        // Valid slots must be contiguous from the oldest slot down.
        elig = {v_f[2], v_f[2] & v_f[1], v_f[2] & v_f[1] & v_f[0]};
        stop = elig & (psn_f | halt_f);

        // A stopping slot commits itself but squashes everything younger.
        commit[2] = (state == NORMAL) & elig[2];
        commit[1] = (state == NORMAL) & elig[1] & ~stop[2];
        commit[0] = (state == NORMAL) & elig[0] & ~stop[2] & ~stop[1];

        halt_hit = |(commit & halt_f);
        // Only the last committed slot can carry a precise-state request,
        // and halt on the same slot overrides it.
        rec_vec     = commit & psn_f & ~halt_f;
        recover_hit = |rec_vec;

        rec_target = '0;
        wr_en      = '0;
        wr_ar      = '0;
        wr_pr      = '0;
        fr_pr      = '0;
        for (int i = 0; i < 3; i++) begin
            if (rec_vec[i])
                rec_target = tpc_f[i];
            wr_en[i] = commit[i] & (ar_f[i] != 5'd0);
            if (wr_en[i]) begin
                wr_ar[i] = ar_f[i];
                wr_pr[i] = tnew_f[i];
                fr_pr[i] = told_f[i];
            end
        end

        n_commit = {1'b0, commit[0]} + {1'b0, commit[1]}
                 + {1'b0, commit[2]};
        n_store  = {1'b0, commit[0] & store_f[0]}
                 + {1'b0, commit[1] & store_f[1]}
                 + {1'b0, commit[2] & store_f[2]};

        case (state)
            NORMAL: begin
                if (halt_hit)
                    state_nxt = HALTED;
                else if (recover_hit)
                    state_nxt = RECOVER;
                else
                    state_nxt = NORMAL;
            end
            RECOVER: state_nxt = NORMAL;
            HALTED:  state_nxt = HALTED;
            default: state_nxt = NORMAL;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state         <= NORMAL;
            map_wr_en     <= '0;
            map_wr_ar     <= '0;
            map_wr_pr     <= '0;
            free_en       <= '0;
            free_pr       <= '0;
            sq_retire_num <= '0;
            BPRecoverEN   <= 1'b0;
            recover_pc    <= '0;
            halt          <= 1'b0;
            retired_count <= '0;
        end else begin
            state         <= state_nxt;
            map_wr_en     <= wr_en;
            map_wr_ar     <= wr_ar;
            map_wr_pr     <= wr_pr;
            free_en       <= wr_en;
            free_pr       <= fr_pr;
            sq_retire_num <= n_store;
            BPRecoverEN   <= (state == NORMAL) & recover_hit & ~halt_hit;
            recover_pc    <= rec_target;
            halt          <= (state_nxt == HALTED);
            retired_count <= retired_count + {62'd0, n_commit};
        end
    end

endmodule

// File: tb/tb_retire_stage.sv
// Scoreboard bench for retire_stage: each cycle's expected outputs are
// queued when stimulus is driven and compared after the next clock edge.

`ifndef XLEN
`define XLEN 32
`endif
`ifndef PR
`define PR 6
`endif

module tb_retire_stage;

    localparam int EW = 2*`XLEN + 2*`PR + 9;

    typedef struct packed {
        logic [2:0]            en;
        logic [2:0][4:0]       ar;
        logic [2:0][`PR-1:0]   pr;
        logic [2:0]            fen;
        logic [2:0][`PR-1:0]   fpr;
        logic [1:0]            sq;
        logic                  bp;
        logic [`XLEN-1:0]      rpc;
        logic                  hlt;
        logic [63:0]           cnt;
    } obs_t;

    logic                       clock = 1'b0;
    logic                       reset = 1'b0;
    logic [3*EW-1:0]            retire_entry = '0;
    logic [2:0]                 map_wr_en;
    logic [2:0][4:0]            map_wr_ar;
    logic [2:0][`PR-1:0]        map_wr_pr;
    logic [2:0]                 free_en;
    logic [2:0][`PR-1:0]        free_pr;
    logic [1:0]                 sq_retire_num;
    logic                       BPRecoverEN;
    logic [`XLEN-1:0]           recover_pc;
    logic                       halt;
    logic [63:0]                retired_count;

    int   n_cmp = 0;
    int   n_bad = 0;
    logic [63:0] exp_cnt = 0;
    obs_t sb[$];

    retire_stage dut (
        .clock         (clock),
        .reset         (reset),
        .retire_entry  (retire_entry),
        .map_wr_en     (map_wr_en),
        .map_wr_ar     (map_wr_ar),
        .map_wr_pr     (map_wr_pr),
        .free_en       (free_en),
        .free_pr       (free_pr),
        .sq_retire_num (sq_retire_num),
        .BPRecoverEN   (BPRecoverEN),
        .recover_pc    (recover_pc),
        .halt          (halt),
        .retired_count (retired_count)
    );

    always #5 clock = ~clock;

    function automatic logic [EW-1:0] ent(
        input logic v, input logic [4:0] a,
        input logic [`PR-1:0] tn, input logic [`PR-1:0] to,
        input logic h, input logic s, input logic p,
        input logic [`XLEN-1:0] t);
        logic [`XLEN-1:0] pc;
        pc = `XLEN'(32'hA000);
        return {v, pc, a, tn, to, h, s, p, t};
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.en  = map_wr_en;
        o.ar  = map_wr_ar;
        o.pr  = map_wr_pr;
        o.fen = free_en;
        o.fpr = free_pr;
        o.sq  = sq_retire_num;
        o.bp  = BPRecoverEN;
        o.rpc = recover_pc;
        o.hlt = halt;
        o.cnt = retired_count;
        return o;
    endfunction

    // Apply one cycle of stimulus, queue its expected response, and step
    // to just after the edge that registers it.
    task automatic drive(input logic [3*EW-1:0] e3, input logic rn,
                         input obs_t e);
        retire_entry = e3;
        reset        = rn;
        sb.push_back(e);
        @(posedge clock);
        #1;
    endtask

    function automatic logic [3*EW-1:0] basic_ents();
        return {ent(1, 3, 40, 10, 0, 0, 0, 0),
                ent(1, 4, 41, 11, 0, 0, 0, 0),
                ent(1, 5, 42, 12, 0, 0, 0, 0)};
    endfunction

    function automatic obs_t basic_exp(input logic [63:0] c);
        obs_t e;
        e = '0;
        e.en = 3'b111;
        e.fen = 3'b111;
        e.ar[2] = 3; e.ar[1] = 4; e.ar[0] = 5;
        e.pr[2] = 40; e.pr[1] = 41; e.pr[0] = 42;
        e.fpr[2] = 10; e.fpr[1] = 11; e.fpr[0] = 12;
        e.cnt = c;
        return e;
    endfunction

    task automatic test_reset();
        obs_t e, got;
        e = '0;
        exp_cnt = 0;
        drive(basic_ents(), 1'b0, e);
        got = sample(); e = sb.pop_front(); n_cmp++;
        if (got !== e) begin
            n_bad++;
            $display("FAIL reset: got %h want %h", got, e);
        end
        e = '0;
        drive('0, 1'b1, e);
        got = sample(); e = sb.pop_front(); n_cmp++;
        if (got !== e) begin
            n_bad++;
            $display("FAIL reset_idle: got %h want %h", got, e);
        end
    endtask

    task automatic test_basic();
        obs_t e, got;
        exp_cnt += 3;
        drive(basic_ents(), 1'b1, basic_exp(exp_cnt));
        got = sample(); e = sb.pop_front(); n_cmp++;
        if (got !== e) begin
            n_bad++;
            $display("FAIL basic: got %h want %h", got, e);
        end
        e = '0; e.cnt = exp_cnt;
        drive('0, 1'b1, e);
        got = sample(); e = sb.pop_front(); n_cmp++;
        if (got !== e) begin
            n_bad++;
            $display("FAIL basic_idle: got %h want %h", got, e);
        end
    endtask

    task automatic test_recover();
        obs_t e, got;
        logic [3*EW-1:0] s;
        s = {ent(1, 6, 30, 13, 0, 0, 1, 32'h100),
             ent(1, 4, 31, 14, 0, 1, 0, 0),
             ent(1, 5, 32, 15, 0, 1, 0, 0)};
        exp_cnt += 1;
        e = '0;
        e.en = 3'b100; e.fen = 3'b100;
        e.ar[2] = 6; e.pr[2] = 30; e.fpr[2] = 13;
        e.bp = 1; e.rpc = 32'h100; e.cnt = exp_cnt;
        drive(s, 1'b1, e);
        got = sample(); e = sb.pop_front(); n_cmp++;
        if (got !== e) begin
            n_bad++;
            $display("FAIL recover_pulse: got %h want %h", got, e);
        end
        e = '0; e.cnt = exp_cnt;
        drive(s, 1'b1, e);
        got = sample(); e = sb.pop_front(); n_cmp++;
        if (got !== e) begin
            n_bad++;
            $display("FAIL recover_ignore: got %h want %h", got, e);
        end
        exp_cnt += 3;
        drive(basic_ents(), 1'b1, basic_exp(exp_cnt));
        got = sample(); e = sb.pop_front(); n_cmp++;
        if (got !== e) begin
            n_bad++;
            $display("FAIL recover_back: got %h want %h", got, e);
        end
        // Cut at slot 1: arch_reg 0 store still counted, slot 0 squashed
        s = {ent(1, 1, 20, 2, 0, 1, 0, 0),
             ent(1, 0, 21, 3, 0, 1, 1, 32'h200),
             ent(1, 3, 22, 4, 0, 1, 0, 0)};
        exp_cnt += 2;
        e = '0;
        e.en = 3'b100; e.fen = 3'b100;
        e.ar[2] = 1; e.pr[2] = 20; e.fpr[2] = 2;
        e.sq = 2; e.bp = 1; e.rpc = 32'h200; e.cnt = exp_cnt;
        drive(s, 1'b1, e);
        got = sample(); e = sb.pop_front(); n_cmp++;
        if (got !== e) begin
            n_bad++;
            $display("FAIL recover_slot1: got %h want %h", got, e);
        end
        e = '0; e.cnt = exp_cnt;
        drive('0, 1'b1, e);
        got = sample(); e = sb.pop_front(); n_cmp++;
        if (got !== e) begin
            n_bad++;
            $display("FAIL recover_slot1_idle: got %h want %h", got, e);
        end
    endtask

    task automatic test_same_reg();
        obs_t e, got;
        logic [3*EW-1:0] s;
        s = {ent(1, 7, 50, 20, 0, 0, 0, 0),
             ent(1, 7, 51, 21, 0, 1, 0, 0),
             ent(1, 0, 52, 22, 0, 0, 0, 0)};
        exp_cnt += 3;
        e = '0;
        e.en = 3'b110; e.fen = 3'b110;
        e.ar[2] = 7; e.ar[1] = 7;
        e.pr[2] = 50; e.pr[1] = 51;
        e.fpr[2] = 20; e.fpr[1] = 21;
        e.sq = 1; e.cnt = exp_cnt;
        drive(s, 1'b1, e);
        got = sample(); e = sb.pop_front(); n_cmp++;
        if (got !== e) begin
            n_bad++;
            $display("FAIL same_reg: got %h want %h", got, e);
        end
    endtask

    task automatic test_contiguous();
        obs_t e, got;
        exp_cnt += 1;
        e = '0;
        e.en = 3'b100; e.fen = 3'b100;
        e.ar[2] = 9; e.pr[2] = 44; e.fpr[2] = 15; e.cnt = exp_cnt;
        drive({ent(1, 9, 44, 15, 0, 0, 0, 0),
               ent(0, 2, 45, 16, 0, 1, 0, 0),
               ent(1, 3, 46, 17, 0, 1, 0, 0)}, 1'b1, e);
        got = sample(); e = sb.pop_front(); n_cmp++;
        if (got !== e) begin
            n_bad++;
            $display("FAIL gap_slot1: got %h want %h", got, e);
        end
        e = '0; e.cnt = exp_cnt;
        drive({ent(0, 9, 44, 15, 0, 0, 1, 32'h40),
               ent(1, 2, 45, 16, 0, 1, 0, 0),
               ent(1, 3, 46, 17, 0, 1, 0, 0)}, 1'b1, e);
        got = sample(); e = sb.pop_front(); n_cmp++;
        if (got !== e) begin
            n_bad++;
            $display("FAIL gap_slot2: got %h want %h", got, e);
        end
        exp_cnt += 3;
        e = '0; e.sq = 3; e.cnt = exp_cnt;
        drive({ent(1, 0, 44, 15, 0, 1, 0, 0),
               ent(1, 0, 45, 16, 0, 1, 0, 0),
               ent(1, 0, 46, 17, 0, 1, 0, 0)}, 1'b1, e);
        got = sample(); e = sb.pop_front(); n_cmp++;
        if (got !== e) begin
            n_bad++;
            $display("FAIL x0_stores: got %h want %h", got, e);
        end
    endtask

    task automatic test_reset_in_recover();
        obs_t e, got;
        e = '0;
        exp_cnt = 0;
        drive({ent(1, 6, 30, 13, 0, 0, 1, 32'h100),
               ent(1, 4, 31, 14, 0, 0, 0, 0),
               ent(1, 5, 32, 15, 0, 0, 0, 0)}, 1'b0, e);
        got = sample(); e = sb.pop_front(); n_cmp++;
        if (got !== e) begin
            n_bad++;
            $display("FAIL reset_vs_pulse: got %h want %h", got, e);
        end
        exp_cnt += 3;
        drive(basic_ents(), 1'b1, basic_exp(exp_cnt));
        got = sample(); e = sb.pop_front(); n_cmp++;
        if (got !== e) begin
            n_bad++;
            $display("FAIL reset_vs_pulse_after: got %h want %h", got, e);
        end
    endtask

    task automatic test_halt_priority();
        obs_t e, got;
        logic [3*EW-1:0] s;
        s = {ent(1, 1, 33, 3, 0, 0, 0, 0),
             ent(1, 2, 34, 4, 1, 0, 1, 32'h300),
             ent(1, 3, 35, 5, 0, 1, 0, 0)};
        exp_cnt += 2;
        e = '0;
        e.en = 3'b110; e.fen = 3'b110;
        e.ar[2] = 1; e.ar[1] = 2;
        e.pr[2] = 33; e.pr[1] = 34;
        e.fpr[2] = 3; e.fpr[1] = 4;
        e.hlt = 1; e.cnt = exp_cnt;
        drive(s, 1'b1, e);
        got = sample(); e = sb.pop_front(); n_cmp++;
        if (got !== e) begin
            n_bad++;
            $display("FAIL halt_over_psn: got %h want %h", got, e);
        end
        e = '0; e.hlt = 1; e.cnt = exp_cnt;
        drive(s, 1'b1, e);
        got = sample(); e = sb.pop_front(); n_cmp++;
        if (got !== e) begin
            n_bad++;
            $display("FAIL halt_hold: got %h want %h", got, e);
        end
        e = '0;
        exp_cnt = 0;
        drive(s, 1'b0, e);
        got = sample(); e = sb.pop_front(); n_cmp++;
        if (got !== e) begin
            n_bad++;
            $display("FAIL halt_reset: got %h want %h", got, e);
        end
        e = '0;
        drive('0, 1'b1, e);
        got = sample(); e = sb.pop_front(); n_cmp++;
        if (got !== e) begin
            n_bad++;
            $display("FAIL halt_reset_idle: got %h want %h", got, e);
        end
    endtask

    task automatic test_halt();
        obs_t e, got;
        logic [3*EW-1:0] s;
        s = {ent(1, 8, 36, 6, 0, 1, 0, 0),
             ent(1, 9, 37, 7, 1, 0, 0, 0),
             ent(1, 10, 38, 8, 0, 1, 0, 0)};
        exp_cnt += 2;
        e = '0;
        e.en = 3'b110; e.fen = 3'b110;
        e.ar[2] = 8; e.ar[1] = 9;
        e.pr[2] = 36; e.pr[1] = 37;
        e.fpr[2] = 6; e.fpr[1] = 7;
        e.sq = 1; e.hlt = 1; e.cnt = exp_cnt;
        drive(s, 1'b1, e);
        got = sample(); e = sb.pop_front(); n_cmp++;
        if (got !== e) begin
            n_bad++;
            $display("FAIL halt_commit: got %h want %h", got, e);
        end
        for (int i = 0; i < 10; i++) begin
            e = '0; e.hlt = 1; e.cnt = exp_cnt;
            drive(basic_ents(), 1'b1, e);
            got = sample(); e = sb.pop_front(); n_cmp++;
            if (got !== e) begin
                n_bad++;
                $display("FAIL halted_%0d: got %h want %h", i, got, e);
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        retire_entry = '0;
        repeat (2) @(posedge clock);
        #1;
        test_reset();
        test_basic();
        test_recover();
        test_same_reg();
        test_contiguous();
        test_reset_in_recover();
        test_halt_priority();
        test_halt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
